// File: rtl/bit_err_pkg.sv
// Shared definitions for consumers of the 3-bit XOR difference vector.
package bit_err_pkg;

  localparam int DIFF_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/popcount3.sv
// Combinational population count of a 3-bit difference vector (0..3).
module popcount3
  import bit_err_pkg::*;
(
  input  logic [DIFF_W-1:0] diff,
  output logic [1:0]        cnt
);

  assign cnt = 2'(diff[0]) + 2'(diff[1]) + 2'(diff[2]);

endmodule

// File: rtl/bit_error_counter.sv
// Windowed mismatching-bit counter: sums popcount(diff) over WINDOW accepted
// samples, then reports a saturated total and a threshold alarm.
module bit_error_counter
  import bit_err_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              diff_valid,
  input  logic [DIFF_W-1:0] diff,
  output logic              diff_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count,
  output logic              count_valid,
  output logic              alarm
);

  localparam int SCNT_W = $clog2(WINDOW + 1);
  localparam int SUM_W  = CNT_W + 2;
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(WINDOW - 1);
  localparam logic [SUM_W-1:0]  SAT_MAX     = {2'b00, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0]  THRESH_W    = SUM_W'(THRESH);

  state_t            state, state_next;
  logic [SCNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0]  acc;
  logic [1:0]        pc;
  logic [SUM_W-1:0]  sum_raw, sum_sat;
  logic              handshake, last_sample;

  popcount3 u_popcount (
    .diff (diff),
    .cnt  (pc)
  );

  // Two spare bits hold any single-step overflow so the clamp sees the true sum.
  assign sum_raw     = {2'b00, acc} + SUM_W'(pc);
  assign sum_sat     = (sum_raw > SAT_MAX) ? SAT_MAX : sum_raw;
  assign handshake   = diff_valid && diff_ready;
  assign last_sample = (sample_cnt == LAST_SAMPLE);

  // Handshake-side outputs decode registered state only.
  assign diff_ready  = (state == ST_ACCUM);
  assign busy        = (state != ST_IDLE);
  assign count_valid = (state == ST_DONE);

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_ACCUM;
      ST_ACCUM: if (handshake && last_sample) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
      err_count  <= '0;
      alarm      <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (handshake) begin
      acc        <= sum_sat[CNT_W-1:0];
      sample_cnt <= sample_cnt + 1'b1;
      if (last_sample) begin
        err_count <= sum_sat[CNT_W-1:0];
        alarm     <= (sum_sat >= THRESH_W);
      end
    end
  end

endmodule

// File: tb/tb_bit_error_counter.sv
// Bench for bit_error_counter: two instances (8-bit and 3-bit accumulators) share
// one stimulus stream and are compared every cycle against a window-level model.
module tb_bit_error_counter;

  localparam int WIN  = 4;
  localparam int THR  = 4;
  localparam int CW_A = 8;
  localparam int CW_B = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            diff_valid = 1'b0;
  logic [2:0]      diff = 3'b000;

  logic            ready_a, busy_a, cv_a, alarm_a;
  logic [CW_A-1:0] err_a;
  logic            ready_b, busy_b, cv_b, alarm_b;
  logic [CW_B-1:0] err_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit compare_en = 1'b0;

  always #5 clk = ~clk;

  bit_error_counter #(.WINDOW(WIN), .CNT_W(CW_A), .THRESH(THR)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .diff_valid(diff_valid), .diff(diff),
    .diff_ready(ready_a), .busy(busy_a), .err_count(err_a),
    .count_valid(cv_a), .alarm(alarm_a)
  );

  bit_error_counter #(.WINDOW(WIN), .CNT_W(CW_B), .THRESH(THR)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .diff_valid(diff_valid), .diff(diff),
    .diff_ready(ready_b), .busy(busy_b), .err_count(err_b),
    .count_valid(cv_b), .alarm(alarm_b)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Window-level model: is a window open, how many samples taken, plain integer total.
  bit in_window, done_cycle;
  int taken, total, exp_err_a, exp_err_b;
  bit exp_alarm_a, exp_alarm_b;

  function automatic int clamp(input int v, input int width);
    int lim = (1 << width) - 1;
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge rst_n) begin
    in_window = 0; done_cycle = 0; taken = 0; total = 0;
    exp_err_a = 0; exp_err_b = 0; exp_alarm_a = 0; exp_alarm_b = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (done_cycle) begin
        done_cycle = 0;
      end else if (in_window) begin
        if (diff_valid) begin
          total += $countones(diff);
          taken++;
          if (taken == WIN) begin
            exp_err_a   = clamp(total, CW_A);
            exp_err_b   = clamp(total, CW_B);
            exp_alarm_a = (exp_err_a >= THR);
            exp_alarm_b = (exp_err_b >= THR);
            in_window   = 0;
            done_cycle  = 1;
          end
        end
      end else if (start) begin
        in_window = 1; taken = 0; total = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("ready_a", int'(ready_a), int'(in_window));
      check("busy_a",  int'(busy_a),  int'(in_window || done_cycle));
      check("cv_a",    int'(cv_a),    int'(done_cycle));
      check("err_a",   int'(err_a),   exp_err_a);
      check("alarm_a", int'(alarm_a), int'(exp_alarm_a));
      check("ready_b", int'(ready_b), int'(in_window));
      check("cv_b",    int'(cv_b),    int'(done_cycle));
      check("err_b",   int'(err_b),   exp_err_b);
      check("alarm_b", int'(alarm_b), int'(exp_alarm_b));
    end
  end

  // Runs one window of four samples; lat counts edges after the start edge until
  // count_valid is seen (4 with no gaps).
  task automatic run_window(input logic [2:0] s [4], input int gap,
                            input bit poke_start, output int lat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          diff_valid = 1'b0;
          diff = 3'b111;
          start = poke_start;
          @(posedge clk); #1 start = 1'b0;
          lat++;
        end
      end
      diff_valid = 1'b1;
      diff = s[i];
      @(posedge clk); #1;
      lat++;
    end
    diff_valid = 1'b0;
    diff = 3'b000;
    while (!cv_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!cv_a) check("cv_timeout", 0, 1);
  endtask

  int lat;

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    compare_en = 1'b1;
    check("rst_err_a", int'(err_a), 0);
    check("rst_busy_a", int'(busy_a), 0);

    // Basic window, no gaps.
    run_window('{3'b111, 3'b000, 3'b101, 3'b001}, 0, 1'b0, lat);
    check("basic_lat", lat, 4);
    check("basic_err", int'(err_a), 6);
    check("basic_alarm", int'(alarm_a), 1);
    check("basic_err_b", int'(err_b), 6);
    // start while in DONE is ignored: one cycle later we are back in IDLE.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("done_start_ignored", int'(busy_a), 0);
    @(posedge clk); #1;
    check("still_idle", int'(busy_a), 0);

    // Gaps of two cycles between samples.
    run_window('{3'b111, 3'b000, 3'b101, 3'b001}, 2, 1'b0, lat);
    check("gap_lat", lat, 10);
    check("gap_err", int'(err_a), 6);

    // Saturation of the 3-bit instance.
    run_window('{3'b111, 3'b111, 3'b111, 3'b111}, 0, 1'b0, lat);
    check("sat_err_b", int'(err_b), 7);
    check("sat_alarm_b", int'(alarm_b), 1);
    check("sat_err_a", int'(err_a), 12);

    // Below threshold, with start pulses during ACCUM.
    run_window('{3'b001, 3'b000, 3'b010, 3'b000}, 1, 1'b1, lat);
    check("low_lat", lat, 7);
    check("low_err", int'(err_a), 2);
    check("low_alarm", int'(alarm_a), 0);

    // Re-establish err_count = 6, then abort a window with reset.
    run_window('{3'b111, 3'b000, 3'b101, 3'b001}, 0, 1'b0, lat);
    check("pre_rst_err", int'(err_a), 6);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    diff_valid = 1'b1; diff = 3'b111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_err", int'(err_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_ready", int'(ready_a), 0);
    check("mid_rst_cv", int'(cv_a), 0);
    diff_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cv", int'(cv_a), 0);
    run_window('{3'b011, 3'b001, 3'b000, 3'b100}, 0, 1'b0, lat);
    check("fresh_err", int'(err_a), 4);
    check("fresh_alarm", int'(alarm_a), 1);

    // Idle: valid data without start is never accepted.
    @(posedge clk); #1;
    diff_valid = 1'b1; diff = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_ready", int'(ready_a), 0);
    end
    diff_valid = 1'b0;
    check("idle_err_held", int'(err_a), 4);
    @(posedge clk); #1;

    compare_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bit_error_counter.md
# bit_error_counter

Windowed bit-mismatch counter that consumes the 3-bit XOR difference vector produced by the bitwise-compare stage directly upstream. Each difference sample `diff = a ^ b` contributes its population count (0–3) to an accumulator. After a programmable window of accepted samples, the block reports the total mismatching-bit count and a threshold alarm. It sits between the XOR comparator and the status/readout logic.

## Interface
- `WINDOW`, default 16: samples accepted per measurement window; legal range ≥ 1.
- `CNT_W`, default 8: width of the accumulator and of `err_count`.
- `THRESH`, default 4: alarm threshold; `alarm` is set when the total is ≥ `THRESH`.
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): asynchronous, active-low reset. It clears all state immediately on assertion.
- `start` (in, 1): single-cycle request to begin a window. Honoured only in IDLE.
- `diff_valid` (in, 1): the upstream difference sample is valid.
- `diff` (in, 3): XOR difference vector; bit i = 1 means a mismatch on lane i.
- `diff_ready` (out, 1): the block accepts a sample this cycle.
- `busy` (out, 1): high in ACCUM and DONE.
- `err_count` (out, CNT_W): total from the last completed window; held until the next window completes.
- `count_valid` (out, 1): one-cycle pulse when `err_count` is updated.
- `alarm` (out, 1): `err_count >= THRESH`; updated together with `err_count`.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - `diff_ready = 0`.
  - `start = 1` → ACCUM. On the same edge the accumulator and the sample counter are cleared.
- **ACCUM**
  - `diff_ready = 1`.
  - A handshake occurs when `diff_valid && diff_ready`. On each handshake:
    - the accumulator adds `popcount(diff)`;
    - the sample counter increments.
  - Cycles without `diff_valid` are gaps; the accumulator and counter hold.
  - On the handshake where the sample counter equals `WINDOW-1`, the same edge does all of the following:
    - writes (accumulator + popcount) to `err_count`;
    - writes the comparison result to `alarm`;
    - moves the state to DONE.
- **DONE**
  - `count_valid = 1` and `diff_ready = 0`.
  - Next state is unconditionally IDLE.
- `start` in ACCUM or DONE is ignored; there is no queueing.
- Arithmetic:
  - The popcount is 2 bits wide, zero-extended to CNT_W.
  - The addition saturates at 2^CNT_W − 1; there is no wrap-around.
  - The sample counter is `$clog2(WINDOW+1)` bits wide.
- Reset values:
  - state = IDLE;
  - `err_count` = 0, `alarm` = 0, `count_valid` = 0, `busy` = 0, `diff_ready` = 0;
  - accumulator = 0, sample counter = 0.
- Reset asserted mid-window aborts the window. No `count_valid` is produced, and the previous `err_count` is lost (it becomes 0).

## Timing
- `diff_ready` and `busy` are decoded from registered state. There is no combinational path from `diff_valid` to `diff_ready`.
- The first sample can be accepted in the cycle after the `start` edge.
- Latency: `count_valid` is high in the cycle immediately after the final handshake edge.
- With no gaps, one window takes 1 + WINDOW + 1 cycles, from the `start` edge to the return to IDLE.
- A new `start` may be presented in the first IDLE cycle after DONE, so back-to-back windows have one dead cycle.
- `err_count` and `alarm` are stable except on the edge that enters DONE.

## Structure
- Shared package/include `bit_err_pkg` holds:
  - `DIFF_W = 3`;
  - the state encodings `ST_IDLE = 2'd0`, `ST_ACCUM = 2'd1`, `ST_DONE = 2'd2`.
- Sub-module `popcount3`: purely combinational, `diff[2:0]` → `cnt[1:0]`. It is reused by other diff consumers.
- Top level: FSM, sample counter, saturating accumulator, output registers.

## Test plan
- **Basic window.** WINDOW=4, THRESH=4. Start, then diffs 3'b111, 3'b000, 3'b101, 3'b001 with `diff_valid` held high → one `count_valid` pulse, `err_count` = 6, `alarm` = 1, return to IDLE.
- **Gaps.** Same stimulus with `diff_valid` low for 2 cycles between each sample → identical result, with `count_valid` arriving 6 cycles later.
- **Saturation.** CNT_W=3, WINDOW=4, four samples of 3'b111 → `err_count` = 7 (not 12 mod 8 = 4), `alarm` = 1.
- **Below threshold and ignored start.** THRESH=4, WINDOW=4, samples 3'b001, 3'b000, 3'b010, 3'b000 → `err_count` = 2, `alarm` = 0. Pulsing `start` during ACCUM changes nothing.
- **Reset mid-window.** After a completed window with `err_count` = 6, start a new window. Assert `rst_n` low after 2 samples → all outputs 0 immediately, no `count_valid`. A fresh window then completes normally.
- **Idle behaviour.** `diff_valid` = 1 with no `start` → `diff_ready` stays 0 and the accumulator is unchanged.
